// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and lane constants for the load/store unit
package lsu_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LANES  = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

   // Big-endian lanes: byte offset 0 sits at bit 24, offset 3 at bit 0.
   function automatic logic [4:0] lane_lsb(input logic [1:0] off);
      return {~off, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - pipeline request/response and data-memory signals of the load/store unit
interface lsu_if;

   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_rdata,
      output busy, done, err, rdata, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, mem_addr, mem_wdata, mem_wr_en, mem_rd_en
   );

endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational lane extract/extend for loads and lane merge for stores
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  size_e       size_i,
   input  logic [1:0]  off_i,
   input  logic        sign_ext_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [4:0]  sh;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      sh       = lane_lsb(off_i);
      byte_sel = 8'(word_i >> sh);
      half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
      load_o   = word_i;
      merge_o  = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o  = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            merge_o = (word_i & ~(32'h0000_00FF << sh)) | (32'(wdata_i[7:0]) << sh);
         end
         SZ_HALF: begin
            load_o  = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            merge_o = off_i[1] ? {word_i[31:16], wdata_i[15:0]}
                               : {wdata_i[15:0], word_i[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer over a word-wide data memory
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned halfword/word accesses instead of aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 16384
) (
   input  logic clk,
   input  logic rst_n,
   lsu_if.slave bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   size_e       size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        sext_q, sext_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rword_q, rword_d;
   logic        err_q, err_d;

   size_e       req_size;
   logic        out_of_range;
   logic        misaligned;
   logic        reject;
   logic [1:0]  req_off;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign req_size     = size_e'(bus.size);
   assign out_of_range = bus.addr >= 32'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((req_size == SZ_HALF) && bus.addr[0]) ||
                       (req_size[1] && (bus.addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign reject = out_of_range | misaligned;

   // Without the trap, low address bits below the access size are dropped.
   always_comb begin
      case (req_size)
         SZ_BYTE: req_off = bus.addr[1:0];
         SZ_HALF: req_off = {bus.addr[1], 1'b0};
         default: req_off = 2'b00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      size_d  = size_q;
      off_d   = off_q;
      sext_d  = sext_q;
      wdata_d = wdata_q;
      rword_d = rword_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               addr_d  = {bus.addr[31:2], 2'b00};
               we_d    = bus.we;
               size_d  = req_size;
               off_d   = req_off;
               sext_d  = bus.sign_ext;
               wdata_d = bus.wdata;
               err_d   = reject;
               if (reject)                      state_d = RESP;
               else if (bus.we && req_size[1])  state_d = WR;
               else                             state_d = RD;
            end
         end
         RD: begin
            rword_d = bus.mem_rdata;
            state_d = we_q ? WR : RESP;
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         off_q   <= 2'b00;
         sext_q  <= 1'b0;
         wdata_q <= '0;
         rword_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         size_q  <= size_d;
         off_q   <= off_d;
         sext_q  <= sext_d;
         wdata_q <= wdata_d;
         rword_q <= rword_d;
         err_q   <= err_d;
      end
   end

   lsu_byte_lane u_lane (
      .word_i     (rword_q),
      .size_i     (size_q),
      .off_i      (off_q),
      .sign_ext_i (sext_q),
      .wdata_i    (wdata_q),
      .load_o     (load_data),
      .merge_o    (merge_data)
   );

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == RESP);
   assign bus.err       = (state_q == RESP) & err_q;
   assign bus.rdata     = load_data;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = size_q[1] ? wdata_q : merge_data;
   assign bus.mem_rd_en = (state_q == RD);
   assign bus.mem_wr_en = (state_q == WR);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   lsu_if bus ();

   load_store_unit #(.MEM_BYTES(16384)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:4095];

   assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          done_cyc;
   logic        err_s;
   logic [31:0] rdata_s;
   int          rd_cnt, wr_cnt, rd_cyc, wr_cyc;
   logic [31:0] rd_addr;
   int          wr_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
      @(negedge clk);
      bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
      bus.addr = a; bus.wdata = wd;
      @(posedge clk);
      done_cyc = -1; err_s = 1'bx; rdata_s = 'x;
      rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1; rd_addr = 'x;
      for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (!hold) bus.req = 1'b0;
         if (bus.mem_rd_en) begin rd_cnt++; rd_cyc = c; rd_addr = bus.mem_addr; end
         if (bus.mem_wr_en) begin wr_cnt++; wr_cyc = c; end
         if (bus.done) begin done_cyc = c; err_s = bus.err; rdata_s = bus.rdata; end
      end
      bus.req = 1'b0;
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = '0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_err",   32'(bus.err), 32'd0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_maddr", bus.mem_addr, 32'd0);
      chk("rst_mwdat", bus.mem_wdata, 32'd0);
      rst_n = 1'b1;

      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABB_CCDD, 1'b0);
      chk("sw_done_cyc", 32'(done_cyc), 32'd2);
      chk("sw_err", 32'(err_s), 32'd0);
      chk("sw_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("sw_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("sw_mem", mem[4], 32'hAABB_CCDD);

      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("lw_rdata", rdata_s, 32'hAABB_CCDD);
      chk("lw_done_cyc", 32'(done_cyc), 32'd2);
      chk("lw_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("lw_rd_cnt", 32'(rd_cnt), 32'd1);
      chk("lw_rd_addr", rd_addr, 32'h10);

      access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
      chk("lb_11", rdata_s, 32'hFFFF_FFBB);
      access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
      chk("lbu_11", rdata_s, 32'h0000_00BB);
      access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
      chk("lhu_12", rdata_s, 32'h0000_CCDD);
      access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
      chk("lh_10", rdata_s, 32'hFFFF_AABB);
      access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("lbu_10", rdata_s, 32'h0000_00AA);
      access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
      chk("lb_13", rdata_s, 32'hFFFF_FFDD);
      access(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b0);
      chk("lw_rsvd", rdata_s, 32'hAABB_CCDD);

      access(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_5655, 1'b0);
      chk("sb_mem", mem[4], 32'hAABB_55DD);
      chk("sb_rd_cyc", 32'(rd_cyc), 32'd1);
      chk("sb_wr_cyc", 32'(wr_cyc), 32'd2);
      chk("sb_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("sb_done_cyc", 32'(done_cyc), 32'd3);
      chk("sb_err", 32'(err_s), 32'd0);

      access(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_BEEF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("sh13_err", 32'(err_s), 32'd1);
      chk("sh13_done_cyc", 32'(done_cyc), 32'd1);
      chk("sh13_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("sh13_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("sh13_mem", mem[4], 32'hAABB_55DD);
`else
      chk("sh13_err", 32'(err_s), 32'd0);
      chk("sh13_done_cyc", 32'(done_cyc), 32'd3);
      chk("sh13_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("sh13_mem", mem[4], 32'hAABB_BEEF);
`endif

      access(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1'b0);
      chk("oor_err", 32'(err_s), 32'd1);
      chk("oor_done_cyc", 32'(done_cyc), 32'd1);
      chk("oor_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("oor_wr_cnt", 32'(wr_cnt), 32'd0);
      access(1'b1, 2'b10, 1'b0, 32'h4010, 32'h1111_2222, 1'b0);
      chk("oor_sw_wr_cnt", 32'(wr_cnt), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("oor_mem", mem[4], 32'hAABB_55DD);
`else
      chk("oor_mem", mem[4], 32'hAABB_BEEF);
`endif

      access(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 1'b0);
      chk("edge_err", 32'(err_s), 32'd0);
      chk("edge_done_cyc", 32'(done_cyc), 32'd2);

      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABB_CCDD, 1'b1);
      chk("hold_done_cyc", 32'(done_cyc), 32'd2);
      @(negedge clk);
      chk("hold_busy_after", 32'(bus.busy), 32'd0);
      chk("hold_mem", mem[4], 32'hAABB_CCDD);

      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = 32'h12; bus.wdata = 32'h1234_5655;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      chk("arst_in_rd", 32'(bus.mem_rd_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      wr_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_wr_en) wr_seen++;
      end
      chk("arst_wr_seen", 32'(wr_seen), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_mem", mem[4], 32'hAABB_CCDD);
      chk("arst_idle", 32'(bus.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 16384, byte size of the attached data memory; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have port: clk  input  1  single clock for all state.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: req  input  1  access request from the pipeline, sampled only in IDLE.
REQ-005 SHALL have port: we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
REQ-007 SHALL have port: sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port: addr  input  32  byte address.
REQ-009 SHALL have port: wdata  input  32  store data, right-justified.
REQ-010 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  valid with done; 1 = access rejected.
REQ-013 SHALL have port: rdata  output  32  load result, valid while done = 1.
REQ-014 SHALL have ports: mem_addr  output  32; mem_wdata  output  32; mem_wr_en  output  1; mem_rd_en  output  1; mem_rdata  input  32. These drive a word-wide data memory with combinational read and clocked write.

Function
REQ-015 SHALL use states IDLE, RD, WR and RESP.
- IDLE + req: word store -> WR; any load or sub-word store -> RD; rejected access -> RESP with err = 1.
REQ-016 SHALL, in RD, assert mem_rd_en for exactly one cycle and register mem_rdata.
- Load: RD -> RESP.
- Sub-word store: RD -> WR.
REQ-017 SHALL, in WR, assert mem_wr_en for exactly one cycle with the merged word on mem_wdata, then go to RESP.
REQ-018 SHALL, in RESP, pulse done = 1 for one cycle, then go to IDLE; req is accepted again in the following cycle.
REQ-019 SHALL drive mem_addr as {addr[31:2], 2'b00}, latched at accept and held stable through RD and WR.
REQ-020 SHALL use big-endian byte lanes: offset 0 = bits [31:24], offset 3 = bits [7:0]; a halfword at offset 0 = [31:16], at offset 2 = [15:0].
REQ-021 SHALL, for sub-word stores, replace only the addressed lane(s) of the read word with the low bits of wdata.
REQ-022 SHALL right-justify load data and extend it per sign_ext; word loads ignore sign_ext.
REQ-023 SHALL meet these latencies from the accept cycle (cycle 0) to done: load and word store = cycle 2; byte and halfword store = cycle 3.
REQ-024 SHALL ignore req while busy = 1, including when req and done are high in the same cycle.
REQ-025 SHALL reject an access with addr >= MEM_BYTES: err = 1, no mem_rd_en, no mem_wr_en, done in cycle 1.
REQ-026 SHALL hold mem_rd_en and mem_wr_en at 0 in IDLE and RESP.

Reset
REQ-027 SHALL, while rst_n = 0, asynchronously force state = IDLE and busy, done, err, mem_rd_en, mem_wr_en = 0; rdata, mem_addr, mem_wdata = 0.
REQ-028 SHALL abort any in-flight access on reset; no memory write may occur after rst_n falls.

Configuration
REQ-029 SHALL support macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1 or a word with addr[1:0] != 0 is rejected as in REQ-025.
- Undefined: the offending low address bits are treated as 0 and the access proceeds.

Structure
REQ-030 SHALL place the size encoding, state enum and word/byte-lane constants in shared package lsu_pkg.
REQ-031 SHALL implement lane extract/extend and store merge in a combinational sub-module lsu_byte_lane.

Verification
REQ-032 SHALL check: word 0x10 = 0xAABBCCDD; lw 0x10 -> rdata 0xAABBCCDD, done in cycle 2, mem_wr_en never high.
REQ-033 SHALL check: lb 0x11 sign_ext = 1 -> 0xFFFFFFBB; lbu 0x11 -> 0x000000BB; lhu 0x12 -> 0x0000CCDD.
REQ-034 SHALL check: sb 0x12 wdata 0x12345655 -> word 0x10 = 0xAABB55DD; mem_rd_en in cycle 1, mem_wr_en in cycle 2 only, done in cycle 3.
REQ-035 SHALL check: sh 0x13 -> macro defined: err = 1, done in cycle 1, no memory enables; macro undefined: access behaves as sh 0x12.
REQ-036 SHALL check: lw 0x4000 with MEM_BYTES = 16384 -> err = 1, done in cycle 1, memory untouched.
REQ-037 SHALL check: rst_n low during RD of sb 0x12 -> mem_wr_en never asserts, word stays 0xAABBCCDD, busy = 0 immediately.
